// File: rtl/out_index_counter_pkg.sv
// Shared types and default widths for the three-level output-index counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package out_cnt_pkg;

    // Default index widths (column / row / channel).
    localparam int OUT_COL_W = 5;
    localparam int OUT_ROW_W = 5;
    localparam int OUT_CH_W  = 6;

    // Counter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } out_cnt_state_e;

endpackage

// File: rtl/out_index_counter_if.sv
// Control/limit/index bundle between the accumulator array, the counter and write-back.
// Latency: n/a (wires only).
// Backpressure: none; cout is a fire-and-forget strobe.
//
// master: drives clear/start/cout and the limits, observes indices and status.
// slave : the counter itself.
interface out_index_counter_if
    import out_cnt_pkg::*;
#(
    parameter int COL_W = OUT_COL_W,
    parameter int ROW_W = OUT_ROW_W,
    parameter int CH_W  = OUT_CH_W
);
    logic             clear;
    logic             start;
    logic             cout;
    logic [COL_W-1:0] col_max;
    logic [ROW_W-1:0] row_max;
    logic [CH_W-1:0]  ch_max;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [CH_W-1:0]  ch;
    logic             busy;
    logic             last;
    logic             complete;
    logic             done;

    modport master (
        output clear, start, cout, col_max, row_max, ch_max,
        input  col, row, ch, busy, last, complete, done
    );

    modport slave (
        input  clear, start, cout, col_max, row_max, ch_max,
        output col, row, ch, busy, last, complete, done
    );

endinterface

// File: rtl/out_index_counter_edge.sv
// Rising-edge detector: pulse is high for the first cycle that in is high.
// Latency: pulse is combinational from in; one register holds the previous value.
// Backpressure: none.
//
// Ports: clk, rst (async active-high), in (level), pulse (in & ~previous in).
module out_cnt_edge (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);
    logic in_q;
    logic in_d;

    always_comb begin
        in_d = in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_d;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/out_index_counter.sv
// Nested column/row/channel output-index counter advanced by cout, with done/complete.
// Latency: 1 cycle from a qualified cout (or start/clear) to registered indices/status.
// Backpressure: none; cout is ignored outside RUN, and dropped when start/clear coincide.
//
// Ports: clk, rst (async active-high), bus (out_index_counter_if.slave):
//   clear/start/cout + col_max/row_max/ch_max in; col/row/ch, busy, last, complete, done out.
// Build option: define OUT_CNT_EDGE_DETECT_EN to count only rising edges of cout
// (a held cout counts once); otherwise every RUN cycle with cout high counts.
module out_index_counter
    import out_cnt_pkg::*;
#(
    parameter int COL_W = OUT_COL_W,
    parameter int ROW_W = OUT_ROW_W,
    parameter int CH_W  = OUT_CH_W
) (
    input  logic                clk,
    input  logic                rst,
    out_index_counter_if.slave  bus
);

    out_cnt_state_e   state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [COL_W-1:0] col_max_q, col_max_d;
    logic [ROW_W-1:0] row_max_q, row_max_d;
    logic [CH_W-1:0]  ch_max_q, ch_max_d;
    logic             busy_q, busy_d;
    logic             complete_q, complete_d;
    logic             done_q, done_d;

    logic             stb;
    logic             col_at_max;
    logic             row_at_max;
    logic             ch_at_max;
    logic             last;

`ifdef OUT_CNT_EDGE_DETECT_EN
    out_cnt_edge u_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (bus.cout),
        .pulse (stb)
    );
`else
    assign stb = bus.cout;
`endif

    // All comparisons use the limits captured at start, never the live inputs.
    assign col_at_max = (col_q == col_max_q);
    assign row_at_max = (row_q == row_max_q);
    assign ch_at_max  = (ch_q  == ch_max_q);
    assign last       = (state_q == ST_RUN) && col_at_max && row_at_max && ch_at_max;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        ch_d       = ch_q;
        col_max_d  = col_max_q;
        row_max_d  = row_max_q;
        ch_max_d   = ch_max_q;
        busy_d     = busy_q;
        complete_d = complete_q;
        done_d     = 1'b0;

        if (bus.clear) begin
            state_d    = ST_IDLE;
            col_d      = '0;
            row_d      = '0;
            ch_d       = '0;
            busy_d     = 1'b0;
            complete_d = 1'b0;
        end else if (bus.start) begin
            // Restart from any state; a coincident strobe is intentionally dropped.
            state_d    = ST_RUN;
            col_max_d  = bus.col_max;
            row_max_d  = bus.row_max;
            ch_max_d   = bus.ch_max;
            col_d      = '0;
            row_d      = '0;
            ch_d       = '0;
            busy_d     = 1'b1;
            complete_d = 1'b0;
        end else if ((state_q == ST_RUN) && stb) begin
            if (last) begin
                // Final pixel: indices hold at their limits rather than wrapping.
                state_d    = ST_DONE;
                busy_d     = 1'b0;
                complete_d = 1'b1;
                done_d     = 1'b1;
            end else if (!col_at_max) begin
                col_d = col_q + COL_W'(1);
            end else begin
                col_d = '0;
                if (!row_at_max) begin
                    row_d = row_q + ROW_W'(1);
                end else begin
                    // ch cannot exceed ch_max here because last was low.
                    row_d = '0;
                    ch_d  = ch_q + CH_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            ch_q       <= '0;
            col_max_q  <= '0;
            row_max_q  <= '0;
            ch_max_q   <= '0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            ch_q       <= ch_d;
            col_max_q  <= col_max_d;
            row_max_q  <= row_max_d;
            ch_max_q   <= ch_max_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
            done_q     <= done_d;
        end
    end

    assign bus.col      = col_q;
    assign bus.row      = row_q;
    assign bus.ch       = ch_q;
    assign bus.busy     = busy_q;
    assign bus.last     = last;
    assign bus.complete = complete_q;
    assign bus.done     = done_q;

endmodule
